// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl
// Sequences the per-bank flush units of one cache instance.
// Concurrent flush requests merge into a single pass. Core-side requests are
// locked until the front end drains. All banks then get one start pulse, and
// the controller waits until every bank has reported completion. After that,
// each merged requester receives its own response carrying its own tag.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush_req_valid     per-requester flush request
//   flush_req_tag       per-requester tag, requester i at [i*TAG_WIDTH +: TAG_WIDTH]
//   flush_req_ready     high for all requesters in IDLE when no bank is in init
//   flush_rsp_valid     per-requester completion, held until consumed
//   flush_rsp_tag       latched request tags echoed back
//   flush_rsp_ready     per-requester response consume
//   core_req_lock       blocks new core requests into the banks (LOCK/START/WAIT)
//   core_idle           nothing in flight in front end or banks
//   bank_flush_init     bank is running its post-reset tag-init sweep
//   bank_flush_begin    one-cycle flush start, broadcast to all banks
//   bank_flush_end      one-cycle per-bank completion pulse
//   busy                controller is not in IDLE
//
// state | meaning
// IDLE  | accepting requests (unless a bank is still initialising)
// LOCK  | core requests blocked, waiting for core_idle
// START | one-cycle broadcast of bank_flush_begin
// WAIT  | collecting bank_flush_end pulses into done_mask
// RESP  | returning responses; each requester handshakes independently
module cache_flush_ctrl #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 1,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           flush_req_valid,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] flush_req_tag,
  output logic [NUM_REQS-1:0]           flush_req_ready,
  output logic [NUM_REQS-1:0]           flush_rsp_valid,
  output logic [NUM_REQS*TAG_WIDTH-1:0] flush_rsp_tag,
  input  logic [NUM_REQS-1:0]           flush_rsp_ready,
  output logic                          core_req_lock,
  input  logic                          core_idle,
  input  logic [NUM_BANKS-1:0]          bank_flush_init,
  output logic [NUM_BANKS-1:0]          bank_flush_begin,
  input  logic [NUM_BANKS-1:0]          bank_flush_end,
  output logic                          busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOCK  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t                        state, state_nxt;
  logic [NUM_REQS-1:0]           pending_mask, pending_nxt;
  logic [NUM_BANKS-1:0]          done_mask, done_nxt;
  logic [NUM_REQS*TAG_WIDTH-1:0] tag_q, tag_nxt;
  logic [NUM_REQS-1:0]           rsp_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending_mask <= '0;
      done_mask    <= '0;
      tag_q        <= '0;
    end else begin
      state        <= state_nxt;
      pending_mask <= pending_nxt;
      done_mask    <= done_nxt;
      tag_q        <= tag_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pending_nxt      = pending_mask;
    done_nxt         = done_mask;
    tag_nxt          = tag_q;
    flush_req_ready  = '0;
    flush_rsp_valid  = '0;
    core_req_lock    = 1'b0;
    bank_flush_begin = '0;
    rsp_fire         = '0;

    case (state)
      IDLE: begin
        // Ready is gated by reset so that every output is low while reset is held.
        if (!reset && !(|bank_flush_init)) begin
          flush_req_ready = '1;
        end
        if (|(flush_req_valid & flush_req_ready)) begin
          pending_nxt = flush_req_valid;
          for (int i = 0; i < NUM_REQS; i++) begin
            if (flush_req_valid[i]) begin
              tag_nxt[i*TAG_WIDTH +: TAG_WIDTH] = flush_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
          end
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        core_req_lock = 1'b1;
        if (core_idle) begin
          state_nxt = START;
        end
      end
      START: begin
        core_req_lock    = 1'b1;
        bank_flush_begin = '1;
        done_nxt         = '0;
        state_nxt        = WAIT;
      end
      WAIT: begin
        core_req_lock = 1'b1;
        // An end pulse that lands in the same cycle as the last outstanding
        // bank still counts toward completion.
        done_nxt      = done_mask | bank_flush_end;
        if (&done_nxt) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        flush_rsp_valid = pending_mask;
        rsp_fire        = pending_mask & flush_rsp_ready;
        pending_nxt     = pending_mask & ~rsp_fire;
        if (pending_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        done_nxt    = '0;
      end
    endcase
  end

  assign flush_rsp_tag = tag_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_cache_flush_ctrl.sv
module tb_cache_flush_ctrl;
  localparam int NR = 4;
  localparam int NB = 2;
  localparam int TW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    flush_req_valid;
  logic [NR*TW-1:0] flush_req_tag;
  logic [NR-1:0]    flush_req_ready;
  logic [NR-1:0]    flush_rsp_valid;
  logic [NR*TW-1:0] flush_rsp_tag;
  logic [NR-1:0]    flush_rsp_ready;
  logic             core_req_lock;
  logic             core_idle;
  logic [NB-1:0]    bank_flush_init;
  logic [NB-1:0]    bank_flush_begin;
  logic [NB-1:0]    bank_flush_end;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int begin_cnt = 0;
  int rsp_seen = 0;

  cache_flush_ctrl #(.NUM_REQS(NR), .NUM_BANKS(NB), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_tag(flush_req_tag),
    .flush_req_ready(flush_req_ready), .flush_rsp_valid(flush_rsp_valid),
    .flush_rsp_tag(flush_rsp_tag), .flush_rsp_ready(flush_rsp_ready),
    .core_req_lock(core_req_lock), .core_idle(core_idle),
    .bank_flush_init(bank_flush_init), .bank_flush_begin(bank_flush_begin),
    .bank_flush_end(bank_flush_end), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (|bank_flush_begin) begin_cnt++;
    if (|flush_rsp_valid) rsp_seen++;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_req_valid = '0; flush_req_tag = '0; flush_rsp_ready = '0;
    core_idle = 1'b1; bank_flush_init = '0; bank_flush_end = '0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (core_req_lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", core_req_lock); end
    n_cmp++; if (bank_flush_begin !== 2'b00) begin n_err++; $display("FAIL reset_begin: got %b want 00", bank_flush_begin); end
    n_cmp++; if (flush_rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid: got %h want 0", flush_rsp_valid); end
    n_cmp++; if (flush_rsp_tag !== 32'h0) begin n_err++; $display("FAIL reset_rsp_tag: got %h want 0", flush_rsp_tag); end
    n_cmp++; if (flush_req_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready: got %h want 0", flush_req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (flush_req_ready !== 4'hF) begin n_err++; $display("FAIL post_reset_ready: got %h want F", flush_req_ready); end
  endtask

  task automatic test_single();
    int b0;
    b0 = begin_cnt;
    flush_req_valid = 4'b0100; flush_req_tag = 32'h005A_0000; core_idle = 1'b1;
    n_cmp++; if (flush_req_ready !== 4'hF) begin n_err++; $display("FAIL single_ready_T: got %h want F", flush_req_ready); end
    tick(); // T+1
    flush_req_valid = '0; flush_req_tag = '0;
    n_cmp++; if ({busy, core_req_lock, bank_flush_begin} !== 4'b1100) begin n_err++; $display("FAIL single_T1: got busy/lock/begin %b want 1100", {busy, core_req_lock, bank_flush_begin}); end
    n_cmp++; if (flush_req_ready !== 4'h0) begin n_err++; $display("FAIL single_ready_busy: got %h want 0", flush_req_ready); end
    tick(); // T+2
    n_cmp++; if ({core_req_lock, bank_flush_begin} !== 3'b111) begin n_err++; $display("FAIL single_T2_begin: got lock/begin %b want 111", {core_req_lock, bank_flush_begin}); end
    tick(); // T+3
    n_cmp++; if ({core_req_lock, bank_flush_begin} !== 3'b100) begin n_err++; $display("FAIL single_T3: got lock/begin %b want 100", {core_req_lock, bank_flush_begin}); end
    tick(); // T+4
    tick(); // T+5
    bank_flush_end = 2'b01;
    tick(); // T+6
    bank_flush_end = 2'b00;
    n_cmp++; if ({core_req_lock, flush_rsp_valid} !== 5'b10000) begin n_err++; $display("FAIL single_T6_wait: got lock/rsp %b want 10000", {core_req_lock, flush_rsp_valid}); end
    tick(); // T+7
    bank_flush_end = 2'b10;
    n_cmp++; if (core_req_lock !== 1'b1) begin n_err++; $display("FAIL single_T7_lock: got %b want 1", core_req_lock); end
    tick(); // T+8
    bank_flush_end = 2'b00;
    n_cmp++; if ({core_req_lock, flush_rsp_valid} !== 5'b00100) begin n_err++; $display("FAIL single_T8_rsp: got lock/rsp %b want 00100", {core_req_lock, flush_rsp_valid}); end
    n_cmp++; if (flush_rsp_tag[23:16] !== 8'h5A) begin n_err++; $display("FAIL single_T8_tag: got %h want 5A", flush_rsp_tag[23:16]); end
    flush_rsp_ready = 4'hF;
    tick(); // T+9
    flush_rsp_ready = 4'h0;
    n_cmp++; if ({busy, flush_rsp_valid, flush_req_ready} !== 9'b0_0000_1111) begin n_err++; $display("FAIL single_T9_idle: got busy/rsp/ready %b want 000001111", {busy, flush_rsp_valid, flush_req_ready}); end
    n_cmp++; if (begin_cnt - b0 !== 1) begin n_err++; $display("FAIL single_begin_count: got %0d want 1", begin_cnt - b0); end
  endtask

  task automatic test_merge();
    int b0;
    b0 = begin_cnt;
    flush_req_valid = 4'b1001; flush_req_tag = 32'h3300_0011;
    tick(); // T+1
    flush_req_valid = '0; flush_req_tag = '0;
    tick(); // T+2
    tick(); // T+3
    bank_flush_end = 2'b11;
    tick(); // T+4
    bank_flush_end = 2'b00;
    n_cmp++; if (flush_rsp_valid !== 4'b1001) begin n_err++; $display("FAIL merge_rsp_valid: got %b want 1001", flush_rsp_valid); end
    n_cmp++; if ({flush_rsp_tag[31:24], flush_rsp_tag[7:0]} !== 16'h3311) begin n_err++; $display("FAIL merge_tags: got %h want 3311", {flush_rsp_tag[31:24], flush_rsp_tag[7:0]}); end
    flush_rsp_ready = 4'b0001;
    tick(); // T+5
    n_cmp++; if ({busy, flush_rsp_valid} !== 5'b11000) begin n_err++; $display("FAIL merge_after_rsp0: got busy/rsp %b want 11000", {busy, flush_rsp_valid}); end
    flush_rsp_ready = 4'b0000;
    tick(); // T+6
    n_cmp++; if ({busy, flush_rsp_valid} !== 5'b11000) begin n_err++; $display("FAIL merge_hold3: got busy/rsp %b want 11000", {busy, flush_rsp_valid}); end
    flush_rsp_ready = 4'b1000;
    tick(); // T+7
    flush_rsp_ready = 4'b0000;
    n_cmp++; if ({busy, flush_rsp_valid} !== 5'b00000) begin n_err++; $display("FAIL merge_done: got busy/rsp %b want 00000", {busy, flush_rsp_valid}); end
    n_cmp++; if (begin_cnt - b0 !== 1) begin n_err++; $display("FAIL merge_begin_count: got %0d want 1", begin_cnt - b0); end
  endtask

  task automatic test_drain();
    int bad;
    bad = 0;
    flush_req_valid = 4'b0010; flush_req_tag = 32'h0000_C300; core_idle = 1'b0;
    tick();
    flush_req_valid = '0; flush_req_tag = '0;
    for (int i = 0; i < 6; i++) begin
      if ({busy, core_req_lock, bank_flush_begin} !== 4'b1100) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL drain_lock_hold: got %0d bad cycles want 0", bad); end
    n_cmp++; if ({core_req_lock, bank_flush_begin} !== 3'b100) begin n_err++; $display("FAIL drain_still_lock: got lock/begin %b want 100", {core_req_lock, bank_flush_begin}); end
    core_idle = 1'b1;
    tick();
    n_cmp++; if (bank_flush_begin !== 2'b11) begin n_err++; $display("FAIL drain_begin: got %b want 11", bank_flush_begin); end
    tick();
    bank_flush_end = 2'b11;
    tick();
    bank_flush_end = 2'b00;
    n_cmp++; if ({flush_rsp_valid, flush_rsp_tag[15:8]} !== 12'h2C3) begin n_err++; $display("FAIL drain_rsp: got %h want 2C3", {flush_rsp_valid, flush_rsp_tag[15:8]}); end
    flush_rsp_ready = 4'hF;
    tick();
    flush_rsp_ready = 4'h0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_idle: got %b want 0", busy); end
  endtask

  task automatic test_stray_end();
    bank_flush_end = 2'b01;
    tick();
    bank_flush_end = 2'b00;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_idle: got %b want 0", busy); end
    flush_req_valid = 4'b0010; flush_req_tag = 32'h0000_7700;
    tick(); tick(); tick(); // WAIT
    flush_req_valid = '0; flush_req_tag = '0;
    bank_flush_end = 2'b10;
    tick();
    bank_flush_end = 2'b00;
    n_cmp++; if ({core_req_lock, flush_rsp_valid} !== 5'b10000) begin n_err++; $display("FAIL stray_still_wait: got lock/rsp %b want 10000", {core_req_lock, flush_rsp_valid}); end
    bank_flush_end = 2'b01;
    tick();
    bank_flush_end = 2'b00;
    n_cmp++; if ({flush_rsp_valid, flush_rsp_tag[15:8]} !== 12'h277) begin n_err++; $display("FAIL stray_rsp: got %h want 277", {flush_rsp_valid, flush_rsp_tag[15:8]}); end
    flush_rsp_ready = 4'hF;
    tick();
    flush_rsp_ready = 4'h0;
  endtask

  task automatic test_init_and_reset();
    int bad;
    int b0;
    int r0;
    bad = 0;
    reset = 1'b1; bank_flush_init = 2'b10;
    tick();
    reset = 1'b0;
    flush_req_valid = 4'hF; flush_req_tag = 32'hAABB_CCDD;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (flush_req_ready !== 4'h0 || busy !== 1'b0) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL init_gating: got %0d bad cycles want 0", bad); end
    flush_req_valid = '0;
    bank_flush_init = 2'b00;
    #1;
    n_cmp++; if (flush_req_ready !== 4'hF) begin n_err++; $display("FAIL init_release_ready: got %h want F", flush_req_ready); end
    flush_req_valid = 4'b0001; flush_req_tag = 32'h0000_00E1;
    tick(); tick(); tick(); // WAIT
    flush_req_valid = '0;
    n_cmp++; if (core_req_lock !== 1'b1) begin n_err++; $display("FAIL abort_in_wait: got lock %b want 1", core_req_lock); end
    b0 = begin_cnt; r0 = rsp_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({busy, core_req_lock, bank_flush_begin, flush_rsp_valid} !== 8'h00) begin n_err++; $display("FAIL abort_outputs: got %b want 00000000", {busy, core_req_lock, bank_flush_begin, flush_rsp_valid}); end
    n_cmp++; if (flush_rsp_tag !== 32'h0) begin n_err++; $display("FAIL abort_tag: got %h want 0", flush_rsp_tag); end
    bank_flush_end = 2'b11;
    tick();
    bank_flush_end = 2'b00;
    flush_rsp_ready = 4'hF;
    for (int i = 0; i < 10; i++) tick();
    flush_rsp_ready = 4'h0;
    n_cmp++; if (rsp_seen - r0 !== 0) begin n_err++; $display("FAIL abort_no_rsp: got %0d rsp cycles want 0", rsp_seen - r0); end
    n_cmp++; if (begin_cnt - b0 !== 0) begin n_err++; $display("FAIL abort_no_begin: got %0d want 0", begin_cnt - b0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_drain();
    test_stray_end();
    test_init_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
